// File: rtl/button_conditioner.sv
// button_conditioner: per-button synchroniser, debouncer and press/release/long/auto-repeat event generator.
module button_conditioner #(
  parameter int                 N_BTN           = 5,
  parameter int                 DEBOUNCE_CYCLES = 1_000_000,
  parameter int                 HOLD_CYCLES     = 100_000_000,
  parameter int                 REPEAT_CYCLES   = 20_000_000,
  parameter logic [N_BTN-1:0]   REPEAT_MASK     = 5'b01000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long,
  output logic [N_BTN-1:0] btn_repeat,
  output logic             any_press
);
  localparam int DW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int RW = REPEAT_CYCLES > 1 ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_e;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic          s1_q, s2_q, deb_q, lvl_q, prs_q, rel_q, lng_q, rpt_q;
    logic          rise_d, fall_d;
    logic [DW-1:0] dcnt_q;
    logic [HW-1:0] hcnt_q;
    logic [RW-1:0] rcnt_q;
    state_e        st_q;
    // deb_q is the debounced value; lvl_q is its registered copy, so edges are seen as deb_q vs lvl_q
    assign rise_d = deb_q & ~lvl_q;
    assign fall_d = ~deb_q & lvl_q;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        s1_q   <= 1'b0;
        s2_q   <= 1'b0;
        deb_q  <= 1'b0;
        dcnt_q <= '0;
        lvl_q  <= 1'b0;
        prs_q  <= 1'b0;
        rel_q  <= 1'b0;
      end else begin
        s1_q  <= btn_raw[i];
        s2_q  <= s1_q;
        if (s2_q == deb_q) dcnt_q <= '0;
        else if (dcnt_q == D_LAST) begin
          dcnt_q <= '0;
          deb_q  <= ~deb_q;
        end else dcnt_q <= dcnt_q + 1'b1;
        lvl_q <= deb_q;
        prs_q <= rise_d;
        rel_q <= fall_d;
      end
    end
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        st_q   <= IDLE;
        hcnt_q <= '0;
        rcnt_q <= '0;
        lng_q  <= 1'b0;
        rpt_q  <= 1'b0;
      end else begin
        lng_q <= 1'b0;
        rpt_q <= 1'b0;
        case (st_q)
          IDLE: if (rise_d) begin
            st_q   <= PRESSED;
            hcnt_q <= '0;
          end
          PRESSED: if (fall_d) st_q <= IDLE;
          else if (hcnt_q == H_LAST) begin
            st_q   <= HELD;
            hcnt_q <= hcnt_q + 1'b1;
            rcnt_q <= '0;
            lng_q  <= 1'b1;
            rpt_q  <= REPEAT_MASK[i];
          end else hcnt_q <= hcnt_q + 1'b1;
          HELD: if (fall_d) st_q <= IDLE;
          else if (rcnt_q == R_LAST) begin
            rcnt_q <= '0;
            rpt_q  <= REPEAT_MASK[i];
          end else rcnt_q <= rcnt_q + 1'b1;
          default: st_q <= IDLE;
        endcase
      end
    end
    assign btn_level[i]   = lvl_q;
    assign btn_press[i]   = prs_q;
    assign btn_release[i] = rel_q;
    assign btn_long[i]    = lng_q;
    assign btn_repeat[i]  = rpt_q;
  end

  assign any_press = |btn_press;
endmodule
